// File: rtl/krv_test_monitor.sv
// Test-end monitor for krv_c: watches decode PC against programmable end addresses,
// samples the result register after a settle delay and reports pass/fail/timeout.
module krv_test_monitor #(
    parameter int PC_W       = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_END    = 2,
    parameter int CNT_W      = 24,
    parameter int SETTLE_CYC = 1,
    parameter int PASS_VAL   = 1
) (
    input  logic                    cpu_clk,
    input  logic                    porn,
    input  logic                    start,
    input  logic                    clear,
    input  logic [PC_W-1:0]         dec_pc,
    input  logic                    dec_pc_vld,
    input  logic [NUM_END*PC_W-1:0] end_pc,
    input  logic [NUM_END-1:0]      end_en,
    input  logic [CNT_W-1:0]        timeout_lim,
    input  logic [DATA_W-1:0]       result,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic                    timeout,
    output logic [2:0]              end_idx,
    output logic [PC_W-1:0]         end_pc_cap,
    output logic [DATA_W-1:0]       result_cap,
    output logic [CNT_W-1:0]        cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE,
        S_DONE,
        S_TMO
    } state_t;

    localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE_CYC);
    localparam logic [DATA_W-1:0] PASS_WORD   = DATA_W'(PASS_VAL);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       hit;
    logic [2:0] hit_idx;
    logic       tmo_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (&val) ? val : val + CNT_W'(1);
    endfunction

    // Scan from the top so the lowest matching channel is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_END - 1; i >= 0; i--) begin
            if (dec_pc_vld && end_en[i] && (dec_pc == end_pc[i*PC_W +: PC_W])) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    assign tmo_hit = (timeout_lim != '0) && (cycle_cnt == timeout_lim - CNT_W'(1));
    assign busy    = (state == S_RUN) || (state == S_SETTLE);

    always_ff @(posedge cpu_clk or negedge porn) begin
        if (!porn) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            end_idx    <= '0;
            end_pc_cap <= '0;
            result_cap <= '0;
            cycle_cnt  <= '0;
        end else if (clear || start) begin
            state      <= clear ? S_IDLE : S_RUN;
            settle_cnt <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            end_idx    <= '0;
            end_pc_cap <= '0;
            result_cap <= '0;
            cycle_cnt  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    // A hit on the budget's last cycle still counts as a normal end.
                    if (hit) begin
                        end_idx    <= hit_idx;
                        end_pc_cap <= dec_pc;
                        if (SETTLE_CYC == 0) begin
                            result_cap <= result;
                            pass       <= (result == PASS_WORD);
                            fail       <= (result != PASS_WORD);
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            settle_cnt <= SETTLE_INIT;
                            state      <= S_SETTLE;
                        end
                    end else if (tmo_hit) begin
                        timeout <= 1'b1;
                        state   <= S_TMO;
                    end else begin
                        cycle_cnt <= sat_inc(cycle_cnt);
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        result_cap <= result;
                        pass       <= (result == PASS_WORD);
                        fail       <= (result != PASS_WORD);
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_krv_test_monitor.sv
// Directed bench for krv_test_monitor: main instance (SETTLE_CYC=1) plus a
// narrow-counter, zero-settle instance for saturation and same-cycle sampling.
module tb_krv_test_monitor;

    logic        cpu_clk = 1'b0;
    logic        porn;
    logic        start, clear, start2, clear2;
    logic [31:0] dec_pc;
    logic        dec_pc_vld;
    logic [63:0] end_pc;
    logic [1:0]  end_en;
    logic [23:0] timeout_lim;
    logic [3:0]  timeout_lim2;
    logic [31:0] result;

    logic        busy, done, pass, fail, timeout;
    logic [2:0]  end_idx;
    logic [31:0] end_pc_cap, result_cap;
    logic [23:0] cycle_cnt;

    logic        busy2, done2, pass2, fail2, timeout2;
    logic [2:0]  end_idx2;
    logic [31:0] end_pc_cap2, result_cap2;
    logic [3:0]  cycle_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    krv_test_monitor u_dut (
        .cpu_clk(cpu_clk), .porn(porn), .start(start), .clear(clear),
        .dec_pc(dec_pc), .dec_pc_vld(dec_pc_vld), .end_pc(end_pc), .end_en(end_en),
        .timeout_lim(timeout_lim), .result(result),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .end_idx(end_idx), .end_pc_cap(end_pc_cap), .result_cap(result_cap),
        .cycle_cnt(cycle_cnt)
    );

    krv_test_monitor #(.CNT_W(4), .SETTLE_CYC(0)) u_sat (
        .cpu_clk(cpu_clk), .porn(porn), .start(start2), .clear(clear2),
        .dec_pc(dec_pc), .dec_pc_vld(dec_pc_vld), .end_pc(end_pc), .end_en(end_en),
        .timeout_lim(timeout_lim2), .result(result),
        .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .timeout(timeout2),
        .end_idx(end_idx2), .end_pc_cap(end_pc_cap2), .result_cap(result_cap2),
        .cycle_cnt(cycle_cnt2)
    );

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to(input int last);
        for (int pc = 0; pc <= last; pc += 4) begin
            dec_pc     = 32'(pc);
            dec_pc_vld = 1'b1;
            step();
        end
        dec_pc_vld = 1'b0;
    endtask

    task automatic test_reset();
        porn = 1'b1; start = 0; clear = 0; start2 = 0; clear2 = 0;
        dec_pc = 0; dec_pc_vld = 0; end_pc = 0; end_en = 0;
        timeout_lim = 0; timeout_lim2 = 0; result = 0;
        #2 porn = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, fail, timeout, end_idx, end_pc_cap, result_cap, cycle_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fail=%b tmo=%b idx=%0d pc=%0h res=%0h cnt=%0d, want all 0",
                     busy, done, pass, fail, timeout, end_idx, end_pc_cap, result_cap, cycle_cnt);
        end
        checks++;
        if ({busy2, done2, timeout2, cycle_cnt2} !== '0) begin
            errors++;
            $display("FAIL reset_sat: got busy=%b done=%b tmo=%b cnt=%0d, want 0", busy2, done2, timeout2, cycle_cnt2);
        end
        step();
        #2 porn = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b want 0", busy);
        end
    endtask

    task automatic test_pass();
        end_pc = {32'h0, 32'h48}; end_en = 2'b01; result = 32'd1; timeout_lim = 0;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || cycle_cnt !== 24'd0) begin
            errors++;
            $display("FAIL start_arm: busy=%b cnt=%0d want 1/0", busy, cycle_cnt);
        end
        run_to(32'h48);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL settle_entry: busy=%b done=%b want 1/0", busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL settle_hold: done=%b want 0", done);
        end
        step();
        checks++;
        if ({done, pass, fail, busy, timeout} !== 5'b11000) begin
            errors++;
            $display("FAIL pass_status: done/pass/fail/busy/tmo=%b want 11000", {done, pass, fail, busy, timeout});
        end
        checks++;
        if (end_idx !== 3'd0 || end_pc_cap !== 32'h48 || result_cap !== 32'd1) begin
            errors++;
            $display("FAIL pass_capture: idx=%0d pc=%0h res=%0h want 0/48/1", end_idx, end_pc_cap, result_cap);
        end
        checks++;
        if (cycle_cnt !== 24'd18) begin
            errors++;
            $display("FAIL pass_cycles: cnt=%0d want 18", cycle_cnt);
        end
    endtask

    task automatic test_fail();
        end_pc = {32'h0, 32'h48}; end_en = 2'b01; result = 32'd0;
        pulse_start();
        run_to(32'h48);
        step();
        step();
        checks++;
        if ({done, pass, fail} !== 3'b101 || result_cap !== 32'd0) begin
            errors++;
            $display("FAIL fail_status: done/pass/fail=%b res=%0h want 101/0", {done, pass, fail}, result_cap);
        end
    endtask

    task automatic test_channels();
        end_pc = {32'h48, 32'h100}; end_en = 2'b11; result = 32'd1;
        pulse_start();
        run_to(32'h48);
        step();
        step();
        checks++;
        if (done !== 1'b1 || end_idx !== 3'd1 || end_pc_cap !== 32'h48) begin
            errors++;
            $display("FAIL chan1_hit: done=%b idx=%0d pc=%0h want 1/1/48", done, end_idx, end_pc_cap);
        end
        end_pc = {32'h48, 32'h48};
        pulse_start();
        run_to(32'h48);
        step();
        step();
        checks++;
        if (done !== 1'b1 || end_idx !== 3'd0) begin
            errors++;
            $display("FAIL lowest_wins: done=%b idx=%0d want 1/0", done, end_idx);
        end
    endtask

    task automatic test_timeout();
        end_pc = {32'h0, 32'h48}; end_en = 2'b01; result = 32'd1;
        timeout_lim = 24'd10; dec_pc_vld = 1'b0;
        pulse_start();
        repeat (9) step();
        checks++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: busy=%b tmo=%b want 1/0", busy, timeout);
        end
        step();
        checks++;
        if ({timeout, done, busy} !== 3'b100 || cycle_cnt !== 24'd9) begin
            errors++;
            $display("FAIL timeout_fire: tmo/done/busy=%b cnt=%0d want 100/9", {timeout, done, busy}, cycle_cnt);
        end
        pulse_start();
        repeat (9) step();
        dec_pc = 32'h48; dec_pc_vld = 1'b1;
        step();
        dec_pc_vld = 1'b0;
        step();
        step();
        checks++;
        if ({done, timeout, pass} !== 3'b101) begin
            errors++;
            $display("FAIL hit_beats_timeout: done/tmo/pass=%b want 101", {done, timeout, pass});
        end
        timeout_lim = 0;
    endtask

    task automatic test_no_hit();
        end_pc = {32'h0, 32'h48}; end_en = 2'b01; timeout_lim = 0;
        pulse_start();
        dec_pc = 32'h48; dec_pc_vld = 1'b0;
        repeat (5) step();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL vld_low_ignored: busy=%b done=%b want 1/0", busy, done);
        end
        checks++;
        if (cycle_cnt !== 24'd5) begin
            errors++;
            $display("FAIL stall_counts: cnt=%0d want 5", cycle_cnt);
        end
        end_en = 2'b00; dec_pc_vld = 1'b1;
        repeat (5) step();
        dec_pc_vld = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL disabled_chan: busy=%b done=%b want 1/0", busy, done);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || cycle_cnt !== 24'd0) begin
            errors++;
            $display("FAIL clear_run: busy=%b cnt=%0d want 0/0", busy, cycle_cnt);
        end
    endtask

    task automatic test_saturate();
        end_pc = {32'h0, 32'h48}; end_en = 2'b01; result = 32'd1;
        timeout_lim2 = 4'd0; dec_pc_vld = 1'b0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        repeat (20) step();
        checks++;
        if (cycle_cnt2 !== 4'd15 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL saturate: cnt=%0d busy=%b want 15/1", cycle_cnt2, busy2);
        end
        dec_pc = 32'h48; dec_pc_vld = 1'b1;
        step();
        dec_pc_vld = 1'b0;
        checks++;
        if ({done2, pass2, busy2} !== 3'b110 || result_cap2 !== 32'd1 || cycle_cnt2 !== 4'd15) begin
            errors++;
            $display("FAIL zero_settle: done/pass/busy=%b res=%0h cnt=%0d want 110/1/15",
                     {done2, pass2, busy2}, result_cap2, cycle_cnt2);
        end
    endtask

    task automatic test_control();
        end_pc = {32'h0, 32'h48}; end_en = 2'b01; result = 32'd1;
        pulse_start();
        dec_pc = 32'h48; dec_pc_vld = 1'b1;
        step();
        dec_pc_vld = 1'b0;
        checks++;
        if (busy !== 1'b1 || end_pc_cap !== 32'h48) begin
            errors++;
            $display("FAIL in_settle: busy=%b pc=%0h want 1/48", busy, end_pc_cap);
        end
        #2 porn = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, fail, timeout, end_idx, end_pc_cap, result_cap, cycle_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid_settle: busy=%b done=%b pc=%0h cnt=%0d want all 0", busy, done, end_pc_cap, cycle_cnt);
        end
        #1 porn = 1'b1;
        pulse_start();
        dec_pc = 32'h48; dec_pc_vld = 1'b1;
        step();
        dec_pc_vld = 1'b0;
        step();
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_before_restart: done=%b want 1", done);
        end
        pulse_start();
        checks++;
        if ({done, pass, busy} !== 3'b001 || end_pc_cap !== 32'h0 || result_cap !== 32'h0) begin
            errors++;
            $display("FAIL start_in_done: done/pass/busy=%b pc=%0h res=%0h want 001/0/0", {done, pass, busy}, end_pc_cap, result_cap);
        end
        repeat (3) step();
        start = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cycle_cnt !== 24'd0) begin
            errors++;
            $display("FAIL start_and_clear: busy=%b done=%b cnt=%0d want 0/0/0", busy, done, cycle_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_channels();
        test_timeout();
        test_no_hit();
        test_saturate();
        test_control();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/krv_test_monitor.md
Name: krv_test_monitor

Overview:
- Synthesizable, parametrised test-end monitor for the krv_c core.
- Watches the decode-stage PC against up to NUM_END programmable end addresses and samples a result register after a settle delay.
- Reports pass/fail, or timeout if no end address is reached within a programmable cycle budget.
- Used by simulation benches and FPGA self-test; status outputs drive GPIO/LEDs.

Parameters:
- PC_W, 32, width of decode PC and end addresses
- DATA_W, 32, width of sampled result register
- NUM_END, 2, number of end-address channels (1..8)
- CNT_W, 24, width of cycle counter and timeout limit
- SETTLE_CYC, 1, cycles between end-PC hit and result sampling (0..15)
- PASS_VAL, 1, result value that means pass

Ports:
- cpu_clk  in  1  core clock, all logic on rising edge
- porn  in  1  asynchronous active-low reset
- start  in  1  pulse: arm monitor, clear counter and status
- clear  in  1  pulse: return to IDLE, clear all status
- dec_pc  in  PC_W  decode-stage PC
- dec_pc_vld  in  1  dec_pc holds a valid instruction this cycle
- end_pc  in  NUM_END*PC_W  end addresses; channel i at bits [i*PC_W +: PC_W]
- end_en  in  NUM_END  per-channel enable
- timeout_lim  in  CNT_W  cycle budget; 0 disables timeout
- result  in  DATA_W  result register (gprs_X[3])
- busy  out  1  state is RUN or SETTLE
- done  out  1  sticky: test ended (pass or fail)
- pass  out  1  sticky: done and sampled result == PASS_VAL
- fail  out  1  sticky: done and sampled result != PASS_VAL
- timeout  out  1  sticky: cycle budget exhausted
- end_idx  out  3  index of the channel that hit
- end_pc_cap  out  PC_W  PC value captured at hit
- result_cap  out  DATA_W  sampled result
- cycle_cnt  out  CNT_W  cycles spent in RUN, saturating

Behaviour:
- Reset (porn low, async): state IDLE; all outputs 0.
- States: IDLE, RUN, SETTLE, DONE, TMO.
- IDLE: start -> RUN. On entry to RUN, cycle_cnt, status and captures are zeroed.
- RUN:
  - cycle_cnt increments each cycle and saturates at all-ones.
  - hit = dec_pc_vld & end_en[i] & (dec_pc == end_pc[i]) for any i. The lowest index wins; end_idx and end_pc_cap are registered on the hit cycle.
  - On hit: go to SETTLE if SETTLE_CYC > 0, else sample result the same cycle and go to DONE.
  - Timeout: if timeout_lim != 0 and cycle_cnt == timeout_lim-1 with no hit -> TMO, timeout=1. A hit in the same cycle wins over timeout.
- SETTLE:
  - Down-counter loaded with SETTLE_CYC on the hit.
  - When the counter reaches 0: result_cap <= result; pass/fail set; done=1; -> DONE.
  - cycle_cnt is frozen; further hits are ignored.
- DONE / TMO: outputs held (sticky) until clear or start.
- Priority and control inputs:
  - clear takes priority over start: next state IDLE, status cleared.
  - start in any state re-arms (RUN, counters and status zeroed), including mid-SETTLE.
- Invariants:
  - pass and fail are mutually exclusive and only set together with done.
  - timeout and done are never both 1.
  - busy is combinational from state.
- Disabled channels never hit. With all end_en = 0, only timeout or clear can leave RUN.
- dec_pc is ignored when dec_pc_vld = 0. Stalls holding dec_pc_vld at 0 do not stop cycle_cnt.

Test Plan:
- Reset, then start; dec_pc steps 0x0..0x48 with end_pc[0]=0x48, end_en=01, result=1, SETTLE_CYC=1 -> done=1, pass=1, end_idx=0, end_pc_cap=0x48, result_cap=1, two cycles after the hit.
- Same run with result=0 -> fail=1, pass=0, done=1.
- end_pc[0]=0x100, end_pc[1]=0x48, end_en=11, dec_pc reaches 0x48 first -> end_idx=1. Rerun with both end_pc set to 0x48 -> end_idx=0 (lowest index wins).
- timeout_lim=10, no hit -> timeout=1 with cycle_cnt=9, done=0, busy=0. timeout_lim=10 with a hit at cycle_cnt=9 -> done=1, timeout=0.
- Hit present but dec_pc_vld=0, or end_en=00 -> no hit. timeout_lim=0 -> stays busy indefinitely; cycle_cnt saturates with CNT_W=4 at 15.
- Reset and control interaction:
  - porn low mid-SETTLE -> all outputs 0 immediately.
  - start during DONE -> status cleared, RUN.
  - start and clear together -> IDLE.
